// File: rtl/dummy_sha_pkg.sv
// Shared widths and lane arithmetic for the multi-lane dummy SHA core.
// Lets front-end and compare logic be tested before the real core is integrated.
package dummy_sha_pkg;

  localparam int STATE_W_DEF  = 352;
  localparam int HASH_W_DEF   = 256;
  localparam int DIFF_W_DEF   = 32;
  localparam int DIFF_LSB_DEF = STATE_W_DEF - DIFF_W_DEF;

  // Arithmetic width wide enough for any practical HASH_W; callers truncate
  localparam int LANE_ARITH_W = 512;

  function automatic logic [LANE_ARITH_W-1:0] lane_hash(
    input logic [LANE_ARITH_W-1:0] seed,
    input int                      l
  );
    return seed + LANE_ARITH_W'(unsigned'(l));
  endfunction

endpackage

// File: rtl/sha_delay_line.sv
// Fixed-depth synchronous-reset shift register; every stage clears on reset.
module sha_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dummy_sha_lanes.sv
// Multi-lane dummy SHA core: per-lane pseudo-hash, periodic forced all-zero hit on
// lane 0, and a fixed-latency pipeline for valid/newBlock/hashes/difficulty.
module dummy_sha_lanes
  import dummy_sha_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int DELAY_C = 10,
  parameter int STATE_W = STATE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF,
  parameter int DIFF_W  = DIFF_W_DEF,
  parameter int HITP_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    validIn,
  input  logic                    newBlockIn,
  input  logic [STATE_W-1:0]      initialState,
  input  logic [HITP_W-1:0]       hitPeriod,
  output logic                    validOut,
  output logic                    newBlockOut,
  output logic [LANES*HASH_W-1:0] hash,
  output logic [DIFF_W-1:0]       difficulty,
  output logic [CNT_W-1:0]        hitCount
);

  localparam int DIFF_LSB = STATE_W - DIFF_W;
  localparam int PIPE_W   = 2 + LANES*HASH_W + DIFF_W;

  logic [HITP_W-1:0]       beat_cnt;
  logic [HITP_W-1:0]       idx;
  logic                    hit;
  logic [HASH_W-1:0]       seed;
  logic [LANES*HASH_W-1:0] hash_s0;
  logic [CNT_W-1:0]        hc_base;
  logic [PIPE_W-1:0]       pipe_in;
  logic [PIPE_W-1:0]       pipe_out;

  assign seed    = initialState[HASH_W-1:0];
  assign idx     = newBlockIn ? '0 : beat_cnt;
  // >= rather than == so a shrunken period fires on the next beat instead of wrapping
  assign hit     = validIn && (hitPeriod != '0) && (idx >= hitPeriod - HITP_W'(1));
  assign hc_base = newBlockIn ? '0 : hitCount;

  always_comb begin
    hash_s0 = '0;
    for (int l = 0; l < LANES; l++) begin
      hash_s0[l*HASH_W +: HASH_W] = HASH_W'(lane_hash(LANE_ARITH_W'(seed), l));
    end
    if (hit) hash_s0[HASH_W-1:0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      hitCount <= '0;
    end else if (validIn) begin
      beat_cnt <= hit ? '0 : idx + HITP_W'(1);
      if (hit && (hc_base != '1)) hitCount <= hc_base + CNT_W'(1);
      else                        hitCount <= hc_base;
    end
  end

  assign pipe_in = {validIn, newBlockIn & validIn, hash_s0,
                    initialState[STATE_W-1 -: DIFF_W]};

  sha_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (DELAY_C)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  assign {validOut, newBlockOut, hash, difficulty} = pipe_out;

  generate
    if (DIFF_LSB > HASH_W) begin : g_unused_state
      logic unused_state_bits;
      assign unused_state_bits = ^initialState[DIFF_LSB-1:HASH_W];
    end
  endgenerate

endmodule

// File: tb/tb_dummy_sha_lanes.sv
// Scoreboard bench for dummy_sha_lanes: driver pushes hand-computed expectations,
// a negedge monitor pops and compares whenever validOut is seen.
module tb_dummy_sha_lanes;

  localparam int DELAY_C = 10;

  typedef struct {
    logic [255:0] l0;
    logic [255:0] l1;
    logic [31:0]  diff;
    logic         nb;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         nb_in;
  logic [351:0] state_in;
  logic [7:0]   hp_in;

  logic         valid_out, nb_out;
  logic [511:0] hash;
  logic [31:0]  diff_out;
  logic [15:0]  hit_count;

  logic         s_valid_out, s_nb_out;
  logic [511:0] s_hash;
  logic [31:0]  s_diff_out;
  logic [1:0]   s_hit_count;

  exp_t sb[$];
  exp_t e_m;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dummy_sha_lanes #(.LANES(2), .DELAY_C(DELAY_C)) dut (
    .clk (clk), .rst (rst), .validIn (valid_in), .newBlockIn (nb_in),
    .initialState (state_in), .hitPeriod (hp_in),
    .validOut (valid_out), .newBlockOut (nb_out), .hash (hash),
    .difficulty (diff_out), .hitCount (hit_count)
  );

  dummy_sha_lanes #(.LANES(2), .DELAY_C(DELAY_C), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .validIn (valid_in), .newBlockIn (nb_in),
    .initialState (state_in), .hitPeriod (hp_in),
    .validOut (s_valid_out), .newBlockOut (s_nb_out), .hash (s_hash),
    .difficulty (s_diff_out), .hitCount (s_hit_count)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic nb, input logic [255:0] seed, input logic [31:0] diff,
                      input logic [7:0] hp, input logic exp_hit, input logic [15:0] exp_hc);
    exp_t e;
    valid_in = 1'b1;
    nb_in    = nb;
    hp_in    = hp;
    state_in = {diff, 64'hA5A5_5A5A_0F0F_F0F0, seed};
    e.l0   = exp_hit ? 256'd0 : seed;
    e.l1   = seed + 256'd1;
    e.diff = diff;
    e.nb   = nb;
    e.due  = cyc + DELAY_C;
    sb.push_back(e);
    @(posedge clk); #1;
    check("hitCount", 512'(hit_count), 512'(exp_hc));
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    nb_in    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_in = 1'b0;
    nb_in    = 1'b0;
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_beat: nothing by cycle %0d, expected at cycle %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: validOut=1 at cycle %0d, expected 0", cyc);
      end else begin
        e_m = sb.pop_front();
        check("latency_cycle", 512'(cyc), 512'(e_m.due));
        check("lane0", 512'(hash[255:0]), 512'(e_m.l0));
        check("lane1", 512'(hash[511:256]), 512'(e_m.l1));
        check("difficulty", 512'(diff_out), 512'(e_m.diff));
        check("newBlockOut", 512'(nb_out), 512'(e_m.nb));
      end
    end else if (valid_out !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL validOut_x: got %b expected 0/1", valid_out);
    end
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; nb_in = 1'b0; state_in = '0; hp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_validOut", 512'(valid_out), 512'(0));
    check("reset_newBlockOut", 512'(nb_out), 512'(0));
    check("reset_hash", hash, 512'(0));
    check("reset_difficulty", 512'(diff_out), 512'(0));
    check("reset_hitCount", 512'(hit_count), 512'(0));

    // 1: latency, no forcing
    beat(1'b1, 256'h5, 32'h1d00ffff, 8'd0, 1'b0, 16'd0);
    drain();

    // 2: period 3 -> hits on beats 3, 6, 9
    for (int i = 1; i <= 9; i++)
      beat(i == 1, 256'(32'h100 + i), 32'h1700_0000 + 32'(i), 8'd3,
           (i % 3) == 0, 16'(i / 3));
    drain();

    // 3: lane1 wraps to 0; unqualified newBlockIn is ignored
    beat(1'b0, {256{1'b1}}, 32'hdead_beef, 8'd0, 1'b0, 16'd3);
    valid_in = 1'b0; nb_in = 1'b1;
    @(posedge clk); #1;
    nb_in = 1'b0;
    check("qual_hitCount", 512'(hit_count), 512'(3));
    beat(1'b0, 256'h77, 32'h0000_0077, 8'd2, 1'b1, 16'd4);
    drain();

    // 4: period 8 for 5 beats, then period 2
    for (int i = 1; i <= 5; i++)
      beat(i == 1, 256'(32'h200 + i), 32'h0200_0000, 8'd8, 1'b0, 16'd0);
    for (int i = 6; i <= 10; i++)
      beat(1'b0, 256'(32'h200 + i), 32'h0200_0000, 8'd2, (i % 2) == 0, 16'((i - 4) / 2));
    drain();

    // 5: reset with 4 beats in flight
    beat(1'b1, 256'h301, 32'h3, 8'd3, 1'b0, 16'd0);
    beat(1'b0, 256'h302, 32'h3, 8'd3, 1'b0, 16'd0);
    beat(1'b0, 256'h303, 32'h3, 8'd3, 1'b1, 16'd1);
    beat(1'b0, 256'h304, 32'h3, 8'd3, 1'b0, 16'd1);
    rst = 1'b1; valid_in = 1'b0; nb_in = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_validOut", 512'(valid_out), 512'(0));
    check("rst_hitCount", 512'(hit_count), 512'(0));
    check("rst_hash", hash, 512'(0));
    idle(DELAY_C + 2);
    beat(1'b0, 256'h401, 32'h4, 8'd2, 1'b0, 16'd0);
    beat(1'b0, 256'h402, 32'h4, 8'd2, 1'b1, 16'd1);
    drain();

    // 6: saturation of a 2-bit hitCount, period 1
    for (int i = 1; i <= 6; i++) begin
      beat(i == 1, 256'(32'h500 + i), 32'h5, 8'd1, 1'b1, 16'(i));
      check("sat_hitCount", 512'(s_hit_count), 512'((i > 3) ? 3 : i));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dummy_sha_lanes.md
Name: dummy_sha_lanes

Overview:
- Parametrised multi-lane stand-in for the SHA-256 mining core. It delays block-header state by a fixed latency and emits one pseudo-hash per lane plus the difficulty word.
- It can force a "winning" (all-zero) hash every N accepted beats, so downstream difficulty-compare and result-reporting logic can be tested deterministically before the real core is integrated.
- It sits between the work-dispatch front end and the hash-compare stage, and is port-compatible with the single-lane dummy for LANES=1.

Parameters:
- LANES, 2, number of parallel hash lanes (>=1).
- DELAY_C, 10, pipeline latency in cycles (>=1).
- STATE_W, 352, initialState width.
- HASH_W, 256, hash width per lane.
- DIFF_W, 32, difficulty width, taken from the top DIFF_W bits of initialState.
- HITP_W, 8, width of hitPeriod.
- CNT_W, 16, width of hitCount.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- validIn  in  1  initialState beat valid this cycle.
- newBlockIn  in  1  first beat of a new block; qualified by validIn.
- initialState  in  STATE_W  header state; [HASH_W-1:0] is the hash seed, [STATE_W-1 -: DIFF_W] is the difficulty.
- hitPeriod  in  HITP_W  forced-hit period; 0 disables forcing.
- validOut  out  1  output beat valid.
- newBlockOut  out  1  delayed, qualified newBlockIn.
- hash  out  LANES*HASH_W  lane l occupies [l*HASH_W +: HASH_W].
- difficulty  out  DIFF_W  delayed difficulty.
- hitCount  out  CNT_W  number of forced hits since reset or last new block; saturating.

Behaviour:
- Reset: the clock is clk and the reset is rst; reset is synchronous and active-high. While rst is high at a rising edge, all pipeline stages clear: valid=0, newBlock=0, data=0.
- Reset values: validOut=0, newBlockOut=0, hash=0, difficulty=0, hitCount=0. The beat counter clears to 0.
- Latency: exactly DELAY_C cycles, no stall and no backpressure. A beat presented at edge t appears at the outputs after edge t+DELAY_C. Throughput is one beat per cycle.
- Data fields advance every cycle regardless of valid. Outputs are meaningful only when validOut=1.
- Lane computation, at stage 0 (combinational, before the first register):
  - seed = initialState[HASH_W-1:0].
  - lane l hash = seed + l, modulo 2^HASH_W; wrap-around is allowed.
  - difficulty = initialState[STATE_W-1 -: DIFF_W].
- newBlock qualification: the pipeline carries newBlockIn & validIn. newBlockIn without validIn is ignored entirely.
- Beat counter (HITP_W bits), updated only on accepted beats (validIn=1):
  - idx = newBlockIn ? 0 : cnt.
  - hit = (hitPeriod != 0) && (idx >= hitPeriod-1).
  - Next cnt: if hit, cnt becomes 0; otherwise cnt becomes idx+1.
  - The >= comparison guarantees that shrinking hitPeriod mid-stream still fires a hit on the next beat instead of missing it.
  - hitPeriod is sampled on each accepted beat only.
- Forced hit: when hit=1, lane 0's hash is forced to all zeros at stage 0. Other lanes are unaffected.
- hitCount:
  - Increments on each accepted beat with hit=1 and saturates at all ones.
  - An accepted beat with newBlockIn=1 first resets it to 0, then adds that beat's hit (0 or 1).
  - hitCount is updated at stage 0, so it leads the corresponding hash by DELAY_C cycles.
- Reset mid-operation: all in-flight beats are discarded (validOut=0 from the cycle after reset), and the counter and hitCount restart.

Decomposition:
- Package dummy_sha_pkg holds:
  - default widths (STATE_W, HASH_W, DIFF_W);
  - a function lane_hash(seed, l) returning seed+l;
  - a localparam for the difficulty bit offset.
- Sub-module sha_delay_line #(WIDTH, DEPTH) is a synchronous-reset shift register built from the existing eff register. It is instantiated once with WIDTH = 2 + LANES*HASH_W + DIFF_W (valid, newBlock, hashes, difficulty).
- The top level holds stage-0 lane arithmetic, the beat counter and hitCount.

Test Plan:
1. Latency check: LANES=2, DELAY_C=10, hitPeriod=0. Send one beat with seed=0x5, difficulty=0x1d00ffff. Required: validOut=1 exactly 10 cycles later, lane0=0x5, lane1=0x6, difficulty=0x1d00ffff; validOut=0 on all other cycles.
2. Periodic hits: hitPeriod=3, 9 consecutive beats, first with newBlockIn=1. Required: lane 0 is zero on beats 3, 6 and 9 only; hitCount reaches 3; newBlockOut=1 only on the output of beat 1.
3. Wrap and qualification: seed = all ones. Required: lane1 = 0. Then pulse newBlockIn with validIn=0. Required: no newBlockOut and no counter change.
4. Period change: hitPeriod=8, 5 beats, then change hitPeriod to 2. Required: the 6th beat is a hit (idx 5 >= 1), and hits then fire every 2nd beat.
5. Reset mid-stream: reset for 1 cycle while 4 beats are in flight. Required: none of them emerge; validOut, hitCount and hash are 0 after reset; the next beat after reset is treated as idx 0.
6. Saturation: CNT_W=2, hitPeriod=1, 6 beats. Required: hitCount stops at 3.
